// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the two-port SDRAM arbiter.
package sdram_arb_pkg;

  localparam int ADR_W     = 21;
  localparam int DAT_W     = 16;
  localparam int SDR_ADR_W = 23;

  typedef enum logic [1:0] {IDLE, REQ, ACK} state_e;

  typedef logic port_t;

  // Byte masks: 1 = byte not written; reads never mask
  function automatic logic [1:0] dm_mask(input logic we, input logic [1:0] sel);
    return we ? ~sel : 2'b00;
  endfunction

endpackage

// File: rtl/sdram_arb_if.sv
// Bus-side and controller-side signals of the SDRAM arbiter.
interface sdram_arb_if;
  import sdram_arb_pkg::*;

  logic                 m0_stb, m1_stb;
  logic                 m0_we, m1_we;
  logic [1:0]           m0_sel, m1_sel;
  logic [ADR_W-1:0]     m0_adr, m1_adr;
  logic [DAT_W-1:0]     m0_dat_w, m1_dat_w;
  logic                 m0_ack, m1_ack;
  logic [DAT_W-1:0]     m_dat_r;
  logic                 sdram_ready;
  logic                 sdram_wr_req, sdram_rd_req;
  logic                 sdram_wr_ack, sdram_rd_ack;
  logic [SDR_ADR_W-1:0] sdram_addr;
  logic [DAT_W-1:0]     sdram_wdata;
  logic [DAT_W-1:0]     sdram_rdata;
  logic [1:0]           sdram_be;
  logic                 dm_h, dm_l;
  logic                 tmo_err;

  modport slave (
    input  m0_stb, m1_stb, m0_we, m1_we, m0_sel, m1_sel, m0_adr, m1_adr,
           m0_dat_w, m1_dat_w, sdram_ready, sdram_wr_ack, sdram_rd_ack, sdram_rdata,
    output m0_ack, m1_ack, m_dat_r, sdram_wr_req, sdram_rd_req, sdram_addr,
           sdram_wdata, sdram_be, dm_h, dm_l, tmo_err
  );

  modport master (
    output m0_stb, m1_stb, m0_we, m1_we, m0_sel, m1_sel, m0_adr, m1_adr,
           m0_dat_w, m1_dat_w, sdram_ready, sdram_wr_ack, sdram_rd_ack, sdram_rdata,
    input  m0_ack, m1_ack, m_dat_r, sdram_wr_req, sdram_rd_req, sdram_addr,
           sdram_wdata, sdram_be, dm_h, dm_l, tmo_err
  );

endinterface

// File: rtl/sdram_arb_rr.sv
// Two-way picker: round-robin on contention, or port 0 always first when fixed.
module sdram_arb_rr
  import sdram_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  port_t      last_i,
  input  logic       fixed_i,
  output port_t      grant_o,
  output logic       valid_o
);

  always_comb begin
    valid_o = |req_i;
    if (req_i == 2'b11 && !fixed_i)
      grant_o = ~last_i;
    else
      grant_o = port_t'(!req_i[0]);
  end

endmodule

// File: rtl/sdram_arb.sv
// Shares one SDRAM controller between CPU (port 0) and DMA (port 1), one transaction at a time.
module sdram_arb
  import sdram_arb_pkg::*;
#(
  parameter bit PRIO_FIXED = 1'b0,
  parameter int TMO_W      = 8
) (
  input  logic  clk_p,
  input  logic  sdram_reset,
  sdram_arb_if.slave bus
);

  state_e           state_q, state_d;
  port_t            grant_q, grant_d, last_q, last_d, pick;
  logic             pick_vld;
  logic             we_q, we_d;
  logic [1:0]       be_q, be_d, dm_q, dm_d;
  logic [ADR_W-1:0] adr_q, adr_d;
  logic [DAT_W-1:0] wdat_q, wdat_d, dat_r_q, dat_r_d;
  logic [TMO_W-1:0] tmo_q, tmo_d, tmo_inc;
  logic             tmo_err_q, tmo_err_d;
  logic             stb_g, we_p;
  logic [1:0]       sel_p;

  sdram_arb_rr u_rr (
    .req_i   ({bus.m1_stb, bus.m0_stb}),
    .last_i  (last_q),
    .fixed_i (PRIO_FIXED),
    .grant_o (pick),
    .valid_o (pick_vld)
  );

  always_ff @(posedge clk_p or posedge sdram_reset) begin
    if (sdram_reset) begin
      state_q   <= IDLE;
      grant_q   <= 1'b0;
      last_q    <= 1'b1;
      we_q      <= 1'b0;
      be_q      <= 2'b00;
      dm_q      <= 2'b00;
      adr_q     <= '0;
      wdat_q    <= '0;
      dat_r_q   <= '0;
      tmo_q     <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      we_q      <= we_d;
      be_q      <= be_d;
      dm_q      <= dm_d;
      adr_q     <= adr_d;
      wdat_q    <= wdat_d;
      dat_r_q   <= dat_r_d;
      tmo_q     <= tmo_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  assign stb_g   = grant_q ? bus.m1_stb : bus.m0_stb;
  assign we_p    = pick ? bus.m1_we : bus.m0_we;
  assign sel_p   = pick ? bus.m1_sel : bus.m0_sel;
  assign tmo_inc = tmo_q + TMO_W'(1);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    we_d      = we_q;
    be_d      = be_q;
    dm_d      = dm_q;
    adr_d     = adr_q;
    wdat_d    = wdat_q;
    dat_r_d   = dat_r_q;
    tmo_d     = tmo_q;
    tmo_err_d = tmo_err_q;
    case (state_q)
      IDLE: begin
        if (bus.sdram_ready && pick_vld) begin
          state_d = REQ;
          grant_d = pick;
          we_d    = we_p;
          be_d    = we_p ? sel_p : 2'b11;
          dm_d    = dm_mask(we_p, sel_p);
          adr_d   = pick ? bus.m1_adr : bus.m0_adr;
          wdat_d  = pick ? bus.m1_dat_w : bus.m0_dat_w;
          tmo_d   = '0;
        end
      end
      REQ: begin
        tmo_d = tmo_inc;
        // A real ack wins over a timeout expiring in the same cycle
        if (we_q ? bus.sdram_wr_ack : bus.sdram_rd_ack) begin
          if (!we_q) dat_r_d = bus.sdram_rdata;
          state_d = ACK;
        end else if (tmo_inc == '1) begin
          state_d   = ACK;
          tmo_err_d = 1'b1;
          dat_r_d   = 16'hFFFF;
        end
      end
      ACK: begin
        if (!stb_g) begin
          state_d = IDLE;
          last_d  = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.sdram_wr_req = (state_q == REQ) && we_q;
  assign bus.sdram_rd_req = (state_q == REQ) && !we_q;
  assign bus.m0_ack       = (state_q == ACK) && !grant_q && bus.m0_stb;
  assign bus.m1_ack       = (state_q == ACK) && grant_q && bus.m1_stb;
  assign bus.m_dat_r      = dat_r_q;
  assign bus.sdram_addr   = {2'b00, adr_q};
  assign bus.sdram_wdata  = wdat_q;
  assign bus.sdram_be     = be_q;
  assign bus.dm_h         = dm_q[1];
  assign bus.dm_l         = dm_q[0];
  assign bus.tmo_err      = tmo_err_q;

endmodule

// File: tb/tb_sdram_arb.sv
// Directed bench for sdram_arb: vector table plus sequences for readiness, timeout, reset and arbitration.
module tb_sdram_arb;
  import sdram_arb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sdram_arb_if a();
  sdram_arb_if b();

  sdram_arb #(.PRIO_FIXED(1'b0), .TMO_W(8)) u_a (.clk_p(clk), .sdram_reset(rst), .bus(a));
  sdram_arb #(.PRIO_FIXED(1'b1), .TMO_W(8)) u_b (.clk_p(clk), .sdram_reset(rst), .bus(b));

  int checks = 0;
  int errors = 0;

  // Controller models: ack one cycle after lat cycles of request, unless muted
  int lat0 = 3;
  bit mute0 = 1'b0;
  int cnt0 = 0;
  int cnt1 = 0;

  always @(negedge clk) begin
    if ((a.sdram_rd_req || a.sdram_wr_req) && !mute0 && !(a.sdram_rd_ack || a.sdram_wr_ack)) begin
      cnt0 = cnt0 + 1;
      if (cnt0 >= lat0) begin
        a.sdram_rd_ack = a.sdram_rd_req;
        a.sdram_wr_ack = a.sdram_wr_req;
        cnt0 = 0;
      end else begin
        a.sdram_rd_ack = 1'b0;
        a.sdram_wr_ack = 1'b0;
      end
    end else begin
      a.sdram_rd_ack = 1'b0;
      a.sdram_wr_ack = 1'b0;
      cnt0 = 0;
    end
  end

  always @(negedge clk) begin
    if ((b.sdram_rd_req || b.sdram_wr_req) && !(b.sdram_rd_ack || b.sdram_wr_ack)) begin
      cnt1 = cnt1 + 1;
      b.sdram_rd_ack = b.sdram_rd_req;
      b.sdram_wr_ack = b.sdram_wr_req;
    end else begin
      b.sdram_rd_ack = 1'b0;
      b.sdram_wr_ack = 1'b0;
    end
  end

  typedef struct {
    bit          port;
    bit          we;
    logic [1:0]  sel;
    logic [20:0] adr;
    logic [15:0] wdat;
    logic [15:0] rdat;
    logic [22:0] e_addr;
    logic [1:0]  e_be;
    bit          e_dmh;
    bit          e_dml;
    logic [15:0] e_datr;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic wait_req(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (a.sdram_rd_req || a.sdram_wr_req) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_ack(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (a.m0_ack || a.m1_ack) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_ack_b(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (b.m0_ack || b.m1_ack) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_vec(input vec_t v);
    bit ok;
    @(negedge clk);
    a.sdram_rdata = v.rdat;
    if (v.port) begin
      a.m1_we = v.we; a.m1_sel = v.sel; a.m1_adr = v.adr; a.m1_dat_w = v.wdat; a.m1_stb = 1'b1;
    end else begin
      a.m0_we = v.we; a.m0_sel = v.sel; a.m0_adr = v.adr; a.m0_dat_w = v.wdat; a.m0_stb = 1'b1;
    end
    wait_req(10, ok);
    chk("vec_req_seen", 32'(ok), 1);
    chk("vec_rd_req", 32'(a.sdram_rd_req), 32'(!v.we));
    chk("vec_wr_req", 32'(a.sdram_wr_req), 32'(v.we));
    chk("vec_addr", 32'(a.sdram_addr), 32'(v.e_addr));
    chk("vec_be", 32'(a.sdram_be), 32'(v.e_be));
    chk("vec_dm", {30'd0, a.dm_h, a.dm_l}, {30'd0, v.e_dmh, v.e_dml});
    if (v.we) chk("vec_wdata", 32'(a.sdram_wdata), 32'(v.wdat));
    wait_ack(50, ok);
    chk("vec_ack_seen", 32'(ok), 1);
    chk("vec_acks", {30'd0, a.m1_ack, a.m0_ack}, v.port ? 32'd2 : 32'd1);
    chk("vec_req_low", {30'd0, a.sdram_rd_req, a.sdram_wr_req}, 0);
    if (!v.we) chk("vec_dat_r", 32'(a.m_dat_r), 32'(v.e_datr));
    a.m0_stb = 1'b0;
    a.m1_stb = 1'b0;
    #1;
    chk("vec_ack_drop", {30'd0, a.m1_ack, a.m0_ack}, 0);
    @(negedge clk);
  endtask

  initial begin
    bit ok;
    int seen;
    vecs[0] = '{1'b0, 1'b0, 2'b11, 21'h000100, 16'h0000, 16'h1234, 23'h000100, 2'b11, 1'b0, 1'b0, 16'h1234};
    vecs[1] = '{1'b1, 1'b1, 2'b10, 21'h1ABCDE, 16'hAB00, 16'h0000, 23'h1ABCDE, 2'b10, 1'b0, 1'b1, 16'h0000};
    vecs[2] = '{1'b0, 1'b1, 2'b01, 21'h000003, 16'h00CD, 16'h0000, 23'h000003, 2'b01, 1'b1, 1'b0, 16'h0000};
    vecs[3] = '{1'b1, 1'b0, 2'b11, 21'h1FFFFF, 16'h0000, 16'hBEEF, 23'h1FFFFF, 2'b11, 1'b0, 1'b0, 16'hBEEF};

    rst = 1'b1;
    a.m0_stb = 1'b0; a.m1_stb = 1'b0; a.m0_we = 1'b0; a.m1_we = 1'b0;
    a.m0_sel = 2'b11; a.m1_sel = 2'b11; a.m0_adr = '0; a.m1_adr = '0;
    a.m0_dat_w = '0; a.m1_dat_w = '0; a.sdram_ready = 1'b0; a.sdram_rdata = '0;
    b.m0_stb = 1'b0; b.m1_stb = 1'b0; b.m0_we = 1'b0; b.m1_we = 1'b0;
    b.m0_sel = 2'b11; b.m1_sel = 2'b11; b.m0_adr = 21'h000010; b.m1_adr = 21'h000020;
    b.m0_dat_w = '0; b.m1_dat_w = '0; b.sdram_ready = 1'b1; b.sdram_rdata = 16'h5A5A;

    repeat (3) @(negedge clk);
    chk("rst_reqs", {30'd0, a.sdram_rd_req, a.sdram_wr_req}, 0);
    chk("rst_acks", {30'd0, a.m1_ack, a.m0_ack}, 0);
    chk("rst_dat_r", 32'(a.m_dat_r), 0);
    chk("rst_addr", 32'(a.sdram_addr), 0);
    chk("rst_wdata", 32'(a.sdram_wdata), 0);
    chk("rst_be_dm", {28'd0, a.sdram_be, a.dm_h, a.dm_l}, 0);
    chk("rst_tmo", 32'(a.tmo_err), 0);
    rst = 1'b0;

    // Controller not ready: strobe held with no request for 100 cycles
    @(negedge clk);
    a.m0_we = 1'b0; a.m0_adr = 21'h000005; a.m0_stb = 1'b1;
    seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (a.sdram_rd_req || a.sdram_wr_req) seen++;
    end
    chk("notready_noreq", 32'(seen), 0);
    a.sdram_ready = 1'b1;
    wait_req(2, ok);
    chk("ready_req_2cyc", 32'(ok), 1);
    wait_ack(50, ok);
    chk("ready_ack", 32'(ok), 1);
    a.m0_stb = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // Timeout: controller silent for the whole REQ phase
    mute0 = 1'b1;
    @(negedge clk);
    a.m0_we = 1'b0; a.m0_adr = 21'h000042; a.m0_stb = 1'b1;
    seen = 0;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (a.sdram_rd_req) seen++;
      if (a.m0_ack) begin
        ok = 1'b1;
        break;
      end
    end
    chk("tmo_ack_seen", 32'(ok), 1);
    chk("tmo_req_cycles", 32'(seen), 255);
    chk("tmo_dat_r", 32'(a.m_dat_r), 32'h0000FFFF);
    chk("tmo_err_set", 32'(a.tmo_err), 1);
    a.m0_stb = 1'b0;
    mute0 = 1'b0;
    @(negedge clk);
    run_vec(vecs[0]);
    chk("tmo_err_sticky", 32'(a.tmo_err), 1);

    // Reset in the middle of REQ; last grant before it was port 0
    mute0 = 1'b1;
    @(negedge clk);
    a.m0_we = 1'b0; a.m0_adr = 21'h000200; a.m0_stb = 1'b1;
    wait_req(10, ok);
    chk("mid_req_seen", 32'(ok), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_req", {30'd0, a.sdram_rd_req, a.sdram_wr_req}, 0);
    chk("mid_rst_ack", {30'd0, a.m1_ack, a.m0_ack}, 0);
    chk("mid_rst_out", {a.m_dat_r, a.sdram_be, a.dm_h, a.dm_l, a.tmo_err, 11'd0}, 0);
    chk("mid_rst_addr", 32'(a.sdram_addr), 0);
    a.m0_stb = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    mute0 = 1'b0;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (a.m0_ack || a.m1_ack || a.sdram_rd_req) seen++;
    end
    chk("post_rst_quiet", 32'(seen), 0);

    // Both ports contending from reset: round-robin 0,1,0,1
    a.sdram_rdata = 16'h0F0F;
    a.m0_we = 1'b0; a.m1_we = 1'b0; a.m1_adr = 21'h000300;
    a.m0_stb = 1'b1; a.m1_stb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_ack(50, ok);
      chk("rr_ack_seen", 32'(ok), 1);
      chk("rr_grant", {30'd0, a.m1_ack, a.m0_ack}, (i % 2) ? 32'd2 : 32'd1);
      if (a.m1_ack) a.m1_stb = 1'b0;
      else a.m0_stb = 1'b0;
      @(negedge clk);
      a.m0_stb = 1'b1; a.m1_stb = 1'b1;
    end
    a.m0_stb = 1'b0; a.m1_stb = 1'b0;
    @(negedge clk);

    // Fixed priority: port 0 keeps winning while it re-asserts
    b.m0_stb = 1'b1; b.m1_stb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_ack_b(50, ok);
      chk("fix_ack_seen", 32'(ok), 1);
      chk("fix_p0_grant", {30'd0, b.m1_ack, b.m0_ack}, 1);
      b.m0_stb = 1'b0;
      @(negedge clk);
      if (i < 2) b.m0_stb = 1'b1;
    end
    wait_ack_b(50, ok);
    chk("fix_p1_ack_seen", 32'(ok), 1);
    chk("fix_p1_grant", {30'd0, b.m1_ack, b.m0_ack}, 2);
    chk("fix_p1_dat_r", 32'(b.m_dat_r), 32'h00005A5A);
    b.m1_stb = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
